// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: valid/ready operand and result stream bundle
interface pipelined_cla_adder_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, zero;
  logic [WIDTH-1:0] a, b, sum;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-look-ahead adder/subtractor, one GROUP-bit block per stage
module pipelined_cla_adder #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input logic clk,
  input logic rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int S = WIDTH / GROUP;
  if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("WIDTH must be an integer multiple of GROUP");
  end
  logic adv;
  logic [S:0] v_q, v_d, c_q, c_d;
  logic cm_q, cm_d;
  logic [WIDTH-1:0] a_q [S], a_d [S], bx_q [S], bx_d [S];
  logic [WIDTH-1:0] s_q [S+1], s_d [S+1];
  logic [GROUP-1:0] p, g;
  logic [GROUP:0] cc;
  logic t, pp;
  assign adv = !v_q[S] || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = v_q[S];
  assign bus.sum = s_q[S];
  assign bus.cout = c_q[S];
  assign bus.overflow = c_q[S] ^ cm_q;
  assign bus.zero = v_q[S] && (s_q[S] == '0);
  always_comb begin
    p = '0;
    g = '0;
    cc = '0;
    t = 1'b0;
    pp = 1'b1;
    cm_d = 1'b0;
    v_d = '0;
    c_d = '0;
    v_d[0] = bus.in_valid;
    c_d[0] = bus.sub || bus.cin;
    a_d[0] = bus.a;
    bx_d[0] = bus.sub ? ~bus.b : bus.b;
    s_d[0] = '0;
    for (int k = 0; k < S; k++) begin
      p = a_q[k][k*GROUP +: GROUP] ^ bx_q[k][k*GROUP +: GROUP];
      g = a_q[k][k*GROUP +: GROUP] & bx_q[k][k*GROUP +: GROUP];
      cc[0] = c_q[k];
      for (int i = 0; i < GROUP; i++) begin
        t = 1'b0;
        pp = 1'b1;
        for (int j = i; j >= 0; j--) begin
          t = t | (pp & g[j]);
          pp = pp & p[j];
        end
        cc[i+1] = t | (pp & c_q[k]);
      end
      v_d[k+1] = v_q[k];
      c_d[k+1] = cc[GROUP];
      s_d[k+1] = s_q[k];
      s_d[k+1][k*GROUP +: GROUP] = p ^ cc[GROUP-1:0];
      if (k < S - 1) begin
        a_d[k+1] = a_q[k];
        bx_d[k+1] = bx_q[k];
      end else begin
        cm_d = cc[GROUP-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      cm_q <= 1'b0;
      for (int k = 0; k <= S; k++) s_q[k] <= '0;
      for (int k = 0; k < S; k++) begin
        a_q[k] <= '0;
        bx_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      cm_q <= cm_d;
      s_q <= s_d;
      a_q <= a_d;
      bx_q <= bx_d;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and randomized scoreboard bench for two adder configurations
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n8 = 0;
  int n32 = 0;
  bit rnd_ready = 1'b0;
  logic [34:0] q8 [$];
  logic [34:0] q32 [$];
  always #5 clk = ~clk;
  pipelined_cla_adder_if #(.WIDTH(8)) b8 ();
  pipelined_cla_adder_if #(.WIDTH(32)) b32 ();
  pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  function automatic logic [34:0] model(int w, logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    logic [63:0] m, bb, full;
    logic [31:0] s;
    logic co, ov;
    m = (64'd1 << w) - 64'd1;
    bb = (sub ? ~{32'd0, b} : {32'd0, b}) & m;
    full = ({32'd0, a} & m) + bb + (sub ? 64'd1 : {63'd0, cin});
    s = full[31:0] & m[31:0];
    co = full[w];
    ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {(s == 32'd0), ov, co, s};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q8.delete();
      q32.delete();
    end else begin
      if (b8.out_valid && b8.out_ready && q8.size() > 0) begin
        void'(q8.pop_front());
        n8++;
      end
      if (b8.in_valid && b8.in_ready) q8.push_back(model(8, 32'(b8.a), 32'(b8.b), b8.cin, b8.sub));
      if (b32.out_valid && b32.out_ready && q32.size() > 0) begin
        void'(q32.pop_front());
        n32++;
      end
      if (b32.in_valid && b32.in_ready) q32.push_back(model(32, b32.a, b32.b, b32.cin, b32.sub));
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready8", 64'(b8.in_ready), 64'(!b8.out_valid || b8.out_ready));
      chk("in_ready32", 64'(b32.in_ready), 64'(!b32.out_valid || b32.out_ready));
      if (b8.out_valid) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result8 unexpected output sum=%h required=none", b8.sum);
        end else chk("result8", 64'({b8.zero, b8.overflow, b8.cout, 24'd0, b8.sum}), 64'(q8[0]));
      end
      if (b32.out_valid) begin
        if (q32.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result32 unexpected output sum=%h required=none", b32.sum);
        end else chk("result32", 64'({b32.zero, b32.overflow, b32.cout, b32.sum}), 64'(q32[0]));
      end
    end
  end
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      b8.out_ready = ($urandom_range(0, 3) != 0);
      b32.out_ready = ($urandom_range(0, 2) != 0);
    end
  end
  task automatic send8(logic [7:0] a, logic [7:0] b, logic cin, logic sub);
    logic ok = 1'b0;
    b8.in_valid = 1'b1;
    b8.a = a;
    b8.b = b;
    b8.cin = cin;
    b8.sub = sub;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = b8.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send8_timeout", 64'(ok), 64'd1);
    b8.in_valid = 1'b0;
    b8.a = 'x;
    b8.b = 'x;
  endtask
  task automatic send32(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    logic ok = 1'b0;
    b32.in_valid = 1'b1;
    b32.a = a;
    b32.b = b;
    b32.cin = cin;
    b32.sub = sub;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = b32.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send32_timeout", 64'(ok), 64'd1);
    b32.in_valid = 1'b0;
    b32.a = 'x;
    b32.b = 'x;
  endtask
  task automatic dir8(string nm, logic [7:0] a, logic [7:0] b, logic cin, logic sub,
                      logic [7:0] es, logic ec, logic eo, logic ez);
    b8.in_valid = 1'b1;
    b8.a = a;
    b8.b = b;
    b8.cin = cin;
    b8.sub = sub;
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_early"}, 64'(b8.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, 64'(b8.out_valid), 64'd1);
    chk({nm, "_res"}, 64'({b8.zero, b8.overflow, b8.cout, b8.sum}), 64'({ez, eo, ec, es}));
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "CHECKS %0d ERRORS %0d", checks, errors + 1);
  end
  initial begin
    int base;
    logic [7:0] hs;
    logic [2:0] hf;
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    b8.a = '0;
    b8.b = '0;
    b8.cin = 1'b0;
    b8.sub = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    b32.a = '0;
    b32.b = '0;
    b32.cin = 1'b0;
    b32.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_outputs", 64'({b8.sum, b8.cout, b8.overflow, b8.zero}), 64'd0);
    chk("rst_in_ready", 64'(b8.in_ready), 64'd1);
    chk("rst_out_valid32", 64'(b32.out_valid), 64'd0);
    dir8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    dir8("7f_plus_1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    dir8("80_plus_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    dir8("5_minus_7", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    dir8("7_minus_5", 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    dir8("cin_add", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0);
    base = n8;
    fork
      begin
        for (int i = 0; i < 5; i++) send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        for (int n = 0; n < 20 && !b8.out_valid; n++) begin
          @(posedge clk);
          #1;
        end
        chk("stall_rise", 64'(b8.out_valid), 64'd1);
        b8.out_ready = 1'b0;
        hs = b8.sum;
        hf = {b8.cout, b8.overflow, b8.zero};
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(b8.in_ready), 64'd0);
          chk("stall_hold", 64'({b8.out_valid, b8.cout, b8.overflow, b8.zero, b8.sum}), 64'({1'b1, hf, hs}));
          @(posedge clk);
          #1;
        end
        b8.out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 30 && n8 < base + 5; n++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_count", 64'(n8 - base), 64'd5);
    repeat (2) @(posedge clk);
    #1;
    base = n8;
    send8(8'h11, 8'h22, 1'b0, 1'b0);
    send8(8'h33, 8'h44, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("flush_out_valid", 64'(b8.out_valid), 64'd0);
    chk("flush_in_ready", 64'(b8.in_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("flush_no_output", 64'(n8 - base), 64'd0);
    rnd_ready = 1'b1;
    fork
      for (int i = 0; i < 3000; i++) send8(pick8(), pick8(), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 10000; i++) send32($urandom, (i % 16 == 0) ? ~32'd0 : $urandom, 1'($urandom), 1'($urandom));
    join
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    b8.out_ready = 1'b1;
    b32.out_ready = 1'b1;
    for (int n = 0; n < 40 && (q8.size() > 0 || q32.size() > 0); n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain8", 64'(q8.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("total32", 64'(n32), 64'd10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
